// File: rtl/seq_pkg.sv
// Shared types and helpers for the serializer, the 1101 detector bench and the top-level wrapper.
package seq_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width of a bit counter that indexes 0..width-1.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $unsigned($clog2(width));
  endfunction

endpackage

// File: rtl/seq_bit_serializer.sv
// Parallel-in/serial-out stage feeding the 1101 sequence detector.
// Streams WIDTH-bit words one bit per clock with no gap between
// back-to-back words, and holds ser_out low while idle.
module seq_bit_serializer
  import seq_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             last,
  output logic             busy
);

  localparam int unsigned   CW       = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  // Bits of the current word still waiting to be emitted, aligned so the
  // next one to go out sits at the output end.
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             take_c;

  // Bit presented at the output end of a word.
  function automatic logic head(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  // Word after one bit has left through the output end; vacated bits fill with 0.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? (w << 1) : (w >> 1);
  endfunction

  // Ready depends on state only: idle, or on the final bit of a word.
  assign din_ready = (state == IDLE) || last;
  assign take_c    = din_valid && din_ready;
  assign busy      = ser_valid;

  // FSM, shift register, bit counter and registered serial outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      last      <= 1'b0;
    end else if (take_c) begin
      // New word: its first bit goes straight to ser_out, the rest wait in shreg.
      state     <= SHIFT;
      shreg     <= advance(din);
      cnt       <= '0;
      ser_out   <= head(din);
      ser_valid <= 1'b1;
      last      <= 1'b0;
    end else begin
      case (state)
        SHIFT: begin
          if (last) begin
            state     <= IDLE;
            shreg     <= '0;
            cnt       <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            last      <= 1'b0;
          end else begin
            shreg   <= advance(shreg);
            cnt     <= cnt + CW'(1);
            ser_out <= head(shreg);
            last    <= ((cnt + CW'(1)) == CNT_LAST);
          end
        end
        default: begin
          ser_out   <= 1'b0;
          ser_valid <= 1'b0;
          last      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: MSB-first and LSB-first 8-bit
// instances plus a 2-bit instance, with a small 1101 detector model.
module tb_seq_bit_serializer;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  // Instance A: WIDTH=8, MSB first
  logic [7:0] din_a = '0;
  logic       vld_a = 1'b0;
  logic       rdy_a, so_a, sv_a, last_a, busy_a;
  // Instance B: WIDTH=8, LSB first
  logic [7:0] din_b = '0;
  logic       vld_b = 1'b0;
  logic       rdy_b, so_b, sv_b, last_b, busy_b;
  // Instance C: WIDTH=2, MSB first
  logic [1:0] din_c = '0;
  logic       vld_c = 1'b0;
  logic       rdy_c, so_c, sv_c, last_c, busy_c;

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_a (
    .clk(clk), .rst(rst), .din(din_a), .din_valid(vld_a), .din_ready(rdy_a),
    .ser_out(so_a), .ser_valid(sv_a), .last(last_a), .busy(busy_a)
  );

  seq_bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_b (
    .clk(clk), .rst(rst), .din(din_b), .din_valid(vld_b), .din_ready(rdy_b),
    .ser_out(so_b), .ser_valid(sv_b), .last(last_b), .busy(busy_b)
  );

  seq_bit_serializer #(.WIDTH(2), .MSB_FIRST(1'b1)) u_c (
    .clk(clk), .rst(rst), .din(din_c), .din_valid(vld_c), .din_ready(rdy_c),
    .ser_out(so_c), .ser_valid(sv_c), .last(last_c), .busy(busy_c)
  );

  int checks = 0;
  int errors = 0;

  logic [2:0]  hist;
  logic [7:0]  exp8;
  logic [15:0] exp16;
  logic [5:0]  exp6;
  logic [1:0]  words_c [3];
  logic        det;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 1101 detector model: update history with a valid bit, return match.
  task automatic det_step(input logic bit_in, output logic match);
    match = ({hist, bit_in} == 4'b1101);
    hist  = {hist[1:0], bit_in};
  endtask

  initial begin
    // ---------------- reset ----------------
    tick();
    tick();
    chk("rst_ser_out",   32'(so_a),   32'd0);
    chk("rst_ser_valid", 32'(sv_a),   32'd0);
    chk("rst_last",      32'(last_a), 32'd0);
    chk("rst_busy",      32'(busy_a), 32'd0);
    rst = 1'b1;
    tick();
    chk("rst_rel_ready", 32'(rdy_a), 32'd1);
    chk("rst_rel_ready_c", 32'(rdy_c), 32'd1);

    // ---------------- single word D0, MSB first ----------------
    exp8 = 8'b1101_0000;  // shift order, bit for cycle 1 at [7]
    hist = '0;
    din_a = 8'hD0;
    vld_a = 1'b1;
    chk("single_ready0", 32'(rdy_a), 32'd1);
    tick();
    vld_a = 1'b0;
    din_a = 8'h00;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("single_bit%0d", k),   32'(so_a),   32'(exp8[8-k]));
      chk($sformatf("single_valid%0d", k), 32'(sv_a),   32'd1);
      chk($sformatf("single_busy%0d", k),  32'(busy_a), 32'd1);
      chk($sformatf("single_last%0d", k),  32'(last_a), 32'(k == 8));
      chk($sformatf("single_ready%0d", k), 32'(rdy_a),  32'(k == 8));
      det_step(so_a, det);
      chk($sformatf("single_det%0d", k),   32'(det),    32'(k == 4));
      tick();
    end
    chk("single_valid9", 32'(sv_a), 32'd0);
    chk("single_out9",   32'(so_a), 32'd0);
    chk("single_ready9", 32'(rdy_a), 32'd1);

    // ---------------- back-to-back D0 then 0D ----------------
    exp16 = 16'b1101_0000_0000_1101;
    din_a = 8'hD0;
    vld_a = 1'b1;
    chk("b2b_ready0", 32'(rdy_a), 32'd1);
    tick();
    din_a = 8'h0D;
    for (int k = 1; k <= 16; k++) begin
      chk($sformatf("b2b_bit%0d", k),   32'(so_a),   32'(exp16[16-k]));
      chk($sformatf("b2b_valid%0d", k), 32'(sv_a),   32'd1);
      chk($sformatf("b2b_ready%0d", k), 32'(rdy_a),  32'((k == 8) || (k == 16)));
      chk($sformatf("b2b_last%0d", k),  32'(last_a), 32'((k == 8) || (k == 16)));
      if (k == 16) vld_a = 1'b0;
      tick();
    end
    chk("b2b_valid17", 32'(sv_a), 32'd0);
    chk("b2b_out17",   32'(so_a), 32'd0);

    // ---------------- stall: din_valid pulsed mid-word ----------------
    din_a = 8'hD0;
    vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k >= 2 && k <= 5) begin
        vld_a = 1'b1;
        din_a = 8'hFF;
      end else begin
        vld_a = 1'b0;
      end
      if (k <= 8) begin
        chk($sformatf("stall_bit%0d", k),   32'(so_a),  32'(exp8[8-k]));
        chk($sformatf("stall_valid%0d", k), 32'(sv_a),  32'd1);
        chk($sformatf("stall_ready%0d", k), 32'(rdy_a), 32'(k == 8));
      end else begin
        chk("stall_valid9", 32'(sv_a), 32'd0);
        chk("stall_out9",   32'(so_a), 32'd0);
      end
      tick();
    end

    // ---------------- async reset mid-word ----------------
    din_a = 8'hFF;
    vld_a = 1'b1;
    tick();
    vld_a = 1'b0;
    din_a = 8'h00;
    for (int k = 1; k <= 4; k++) tick();
    chk("arst_bit4_pre",   32'(so_a), 32'd1);
    chk("arst_valid_pre",  32'(sv_a), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("arst_out_now",   32'(so_a),   32'd0);
    chk("arst_valid_now", 32'(sv_a),   32'd0);
    chk("arst_last_now",  32'(last_a), 32'd0);
    chk("arst_busy_now",  32'(busy_a), 32'd0);
    tick();
    rst = 1'b1;
    #1;
    chk("arst_rel_ready", 32'(rdy_a), 32'd1);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk($sformatf("arst_quiet_valid%0d", k), 32'(sv_a), 32'd0);
      chk($sformatf("arst_quiet_out%0d", k),   32'(so_a), 32'd0);
    end

    // ---------------- LSB first, 0000_1011 ----------------
    hist = '0;
    din_b = 8'b0000_1011;
    vld_b = 1'b1;
    chk("lsb_ready0", 32'(rdy_b), 32'd1);
    tick();
    vld_b = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      chk($sformatf("lsb_bit%0d", k),  32'(so_b),   32'(exp8[8-k]));
      chk($sformatf("lsb_last%0d", k), 32'(last_b), 32'(k == 8));
      det_step(so_b, det);
      chk($sformatf("lsb_det%0d", k),  32'(det),    32'(k == 4));
      tick();
    end
    chk("lsb_valid9", 32'(sv_b), 32'd0);

    // ---------------- WIDTH=2, three words back-to-back ----------------
    words_c[0] = 2'b11;
    words_c[1] = 2'b01;
    words_c[2] = 2'b10;
    exp6 = 6'b11_01_10;
    vld_c = 1'b1;
    din_c = words_c[0];
    chk("w2_ready0", 32'(rdy_c), 32'd1);
    tick();
    for (int k = 1; k <= 6; k++) begin
      if (k < 6) din_c = words_c[k / 2];
      else vld_c = 1'b0;
      chk($sformatf("w2_bit%0d", k),   32'(so_c),   32'(exp6[6-k]));
      chk($sformatf("w2_valid%0d", k), 32'(sv_c),   32'd1);
      chk($sformatf("w2_last%0d", k),  32'(last_c), 32'((k % 2) == 0));
      chk($sformatf("w2_ready%0d", k), 32'(rdy_c),  32'((k % 2) == 0));
      tick();
    end
    chk("w2_valid7", 32'(sv_c), 32'd0);
    chk("w2_out7",   32'(so_c), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
